vehicle_control_ext: RTL and testbench

Next-generation vehicle control block: a gear-selector FSM with a parametrised number of forward gears and brake/standstill interlocks, plus a turn-indicator FSM with an integrated blink generator, auto-cancel and optional hazard mode. It sits between the driver-input decode logic and the lamp/transmission drivers, and runs on the single vehicle control clock. All outputs are registered.

---
 rtl/vehicle_control_ext.sv | 192 +++++++++++++++++++
 tb/tb_vehicle_control_ext.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_control_ext.sv
// Gear selector with brake/standstill interlocks plus turn indicator with blinker.
// Define VEHICLE_CTRL_HAZARD_EN to enable hazard mode on the hazard input.
module vehicle_control_ext #(
  parameter int NUM_FWD_GEARS = 4,
  parameter int BLINK_HALF = 4,
  localparam int GW = $clog2(NUM_FWD_GEARS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ignition,
  input  logic          brake,
  input  logic          stopped,
  input  logic [1:0]    gear_req,
  input  logic [1:0]    turn_req,
  input  logic          steer_return,
  input  logic          hazard,
  output logic [2:0]    gear_state,
  output logic [GW-1:0] gear_index,
  output logic          shift_reject,
  output logic [1:0]    turn_state,
  output logic          lamp_left,
  output logic          lamp_right
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [2:0] {
    G_LOCK = 3'd0,
    G_PARK = 3'd1,
    G_REV  = 3'd2,
    G_NEU  = 3'd3,
    G_DRV  = 3'd4
  } gear_t;

  typedef enum logic [1:0] {
    T_NONE  = 2'b00,
    T_LEFT  = 2'b01,
    T_HAZ   = 2'b10,
    T_RIGHT = 2'b11
  } turn_t;

  gear_t         g_q, g_d;
  logic [GW-1:0] idx_q, idx_d;
  logic          rej_q, rej_d;
  turn_t         t_q, t_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;
  logic          ll_q, ll_d;
  logic          lr_q, lr_d;
  logic [1:0]    gprev_q, tprev_q;
  logic          gedge, tedge;

`ifndef VEHICLE_CTRL_HAZARD_EN
  logic unused_hazard;
  assign unused_hazard = hazard;
`endif

  assign gedge = (gear_req != 2'b00) && (gear_req != gprev_q);
  assign tedge = (turn_req != 2'b00) && (turn_req != tprev_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      g_q     <= G_LOCK;
      idx_q   <= '0;
      rej_q   <= 1'b0;
      t_q     <= T_NONE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      ll_q    <= 1'b0;
      lr_q    <= 1'b0;
      gprev_q <= 2'b00;
      tprev_q <= 2'b00;
    end else begin
      g_q     <= g_d;
      idx_q   <= idx_d;
      rej_q   <= rej_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      ll_q    <= ll_d;
      lr_q    <= lr_d;
      gprev_q <= gear_req;
      tprev_q <= turn_req;
    end
  end

  // Gear chain: PARK <-> REVERSE <-> NEUTRAL <-> DRIVE(1..N)
  always_comb begin
    g_d   = g_q;
    idx_d = idx_q;
    rej_d = 1'b0;
    if (!ignition) begin
      g_d   = G_LOCK;
      idx_d = '0;
    end else if (g_q == G_LOCK) begin
      g_d = G_PARK;
    end else if (gedge) begin
      case (gear_req)
        2'b11: begin
          if (stopped && g_q != G_PARK) begin
            g_d   = G_PARK;
            idx_d = '0;
          end else begin
            rej_d = 1'b1;
          end
        end
        2'b10: begin
          case (g_q)
            G_PARK: begin
              if (brake && stopped) g_d = G_REV;
              else rej_d = 1'b1;
            end
            G_REV: g_d = G_NEU;
            G_NEU: begin
              g_d   = G_DRV;
              idx_d = GW'(1);
            end
            G_DRV: begin
              if (idx_q < GW'(NUM_FWD_GEARS)) idx_d = idx_q + 1'b1;
              else rej_d = 1'b1;
            end
            default: rej_d = 1'b1;
          endcase
        end
        2'b01: begin
          case (g_q)
            G_REV: g_d = G_PARK;
            G_NEU: begin
              if (stopped) g_d = G_REV;
              else rej_d = 1'b1;
            end
            G_DRV: begin
              if (idx_q == GW'(1)) begin
                g_d   = G_NEU;
                idx_d = '0;
              end else begin
                idx_d = idx_q - 1'b1;
              end
            end
            default: rej_d = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    t_d = t_q;
`ifdef VEHICLE_CTRL_HAZARD_EN
    if (hazard) t_d = T_HAZ;
    else if (t_q == T_HAZ) t_d = T_NONE;
    else
`endif
    if (!ignition) t_d = T_NONE;
    else if (tedge && turn_req == 2'b11) t_d = T_NONE;
    else if (tedge && turn_req == 2'b01)
      t_d = (t_q == T_LEFT) ? T_NONE : T_LEFT;
    else if (tedge && turn_req == 2'b10)
      t_d = (t_q == T_RIGHT) ? T_NONE : T_RIGHT;
    else if (steer_return && (t_q == T_LEFT || t_q == T_RIGHT))
      t_d = T_NONE;
  end

  // Blink phase restarts lit whenever a new indication begins
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (t_d == T_NONE) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (t_d != t_q) begin
      cnt_d = '0;
      ph_d  = 1'b1;
    end else if (cnt_q == CW'(BLINK_HALF - 1)) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    ll_d = ph_d & (t_d == T_LEFT || t_d == T_HAZ);
    lr_d = ph_d & (t_d == T_RIGHT || t_d == T_HAZ);
  end

  assign gear_state   = g_q;
  assign gear_index   = idx_q;
  assign shift_reject = rej_q;
  assign turn_state   = t_q;
  assign lamp_left    = ll_q;
  assign lamp_right   = lr_q;

endmodule

// File: tb/tb_vehicle_control_ext.sv
// Scoreboard bench for vehicle_control_ext at default parameters.
// Expectations follow VEHICLE_CTRL_HAZARD_EN when it is defined.
module tb_vehicle_control_ext;

  localparam int N = 4;
  localparam int H = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ignition = 1'b1;
  logic       brake = 1'b0;
  logic       stopped = 1'b0;
  logic [1:0] gear_req = 2'b00;
  logic [1:0] turn_req = 2'b00;
  logic       steer_return = 1'b0;
  logic       hazard = 1'b0;
  logic [2:0] gear_state;
  logic [2:0] gear_index;
  logic       shift_reject;
  logic [1:0] turn_state;
  logic       lamp_left;
  logic       lamp_right;

  always #5 clock = ~clock;

  vehicle_control_ext #(
    .NUM_FWD_GEARS(N),
    .BLINK_HALF(H)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ignition(ignition),
    .brake(brake),
    .stopped(stopped),
    .gear_req(gear_req),
    .turn_req(turn_req),
    .steer_return(steer_return),
    .hazard(hazard),
    .gear_state(gear_state),
    .gear_index(gear_index),
    .shift_reject(shift_reject),
    .turn_state(turn_state),
    .lamp_left(lamp_left),
    .lamp_right(lamp_right)
  );

  typedef struct packed {
    logic [2:0] gs;
    logic [2:0] gi;
    logic       rej;
    logic [1:0] ts;
    logic       ll;
    logic       lr;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  logic [2:0] e_gs;
  int         e_gi;
  logic       e_rej;
  logic [1:0] e_ts;
  logic [1:0] last_ts;
  int         age;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d",
               tag, $time, obs, exp);
    end
  endtask

  // Lamps are lit in the first H cycles of each 2H window after entry
  task automatic tick(input logic [1:0] g, input logic [1:0] t,
                      input logic sr);
    exp_t e;
    logic lit;
    gear_req = g;
    turn_req = t;
    steer_return = sr;
    if (e_ts != last_ts) age = 0;
    else age++;
    last_ts = e_ts;
    lit = ((age / H) % 2) == 0;
    e.gs = e_gs;
    e.gi = e_gi[2:0];
    e.rej = e_rej;
    e.ts = e_ts;
    e.ll = lit && (e_ts == 2'b01 || e_ts == 2'b10);
    e.lr = lit && (e_ts == 2'b11 || e_ts == 2'b10);
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    chk("gear_state", gear_state, e.gs);
    chk("gear_index", gear_index, e.gi);
    chk("shift_reject", shift_reject, e.rej);
    chk("turn_state", turn_state, e.ts);
    chk("lamp_left", lamp_left, e.ll);
    chk("lamp_right", lamp_right, e.lr);
    e_rej = 1'b0;
  endtask

  task automatic gp(input logic [1:0] g, input logic [2:0] gs,
                    input int gi, input logic rej);
    e_gs = gs;
    e_gi = gi;
    e_rej = rej;
    tick(g, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
  endtask

  task automatic tp(input logic [1:0] t, input logic [1:0] ts);
    e_ts = ts;
    tick(2'b00, t, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    e_gs = 3'd0; e_gi = 0; e_rej = 1'b0;
    e_ts = 2'b00; last_ts = 2'b00; age = 0;

    reset = 1'b1;
    tick(2'b00, 2'b00, 1'b0);
    reset = 1'b0;
    e_gs = 3'd1;
    tick(2'b00, 2'b00, 1'b0);

    gp(2'b10, 3'd1, 0, 1'b1);
    brake = 1'b1;
    stopped = 1'b1;
    gp(2'b10, 3'd2, 0, 1'b0);
    gp(2'b10, 3'd3, 0, 1'b0);
    for (int i = 1; i <= N; i++) gp(2'b10, 3'd4, i, 1'b0);
    gp(2'b10, 3'd4, N, 1'b1);
    gp(2'b10, 3'd4, N, 1'b1);

    gp(2'b01, 3'd4, 3, 1'b0);
    gp(2'b01, 3'd4, 2, 1'b0);
    e_gi = 3;
    repeat (5) tick(2'b10, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
    gp(2'b01, 3'd4, 2, 1'b0);
    gp(2'b01, 3'd4, 1, 1'b0);

    stopped = 1'b0;
    gp(2'b01, 3'd3, 0, 1'b0);
    gp(2'b01, 3'd3, 0, 1'b1);
    gp(2'b11, 3'd3, 0, 1'b1);
    stopped = 1'b1;
    gp(2'b11, 3'd1, 0, 1'b0);
    gp(2'b01, 3'd1, 0, 1'b1);
    gp(2'b11, 3'd1, 0, 1'b1);

    e_ts = 2'b01;
    tick(2'b00, 2'b01, 1'b0);
    repeat (10) tick(2'b00, 2'b00, 1'b0);
    e_ts = 2'b11;
    tick(2'b00, 2'b10, 1'b0);
    repeat (5) tick(2'b00, 2'b00, 1'b0);
    e_ts = 2'b00;
    tick(2'b00, 2'b00, 1'b1);
    repeat (2) tick(2'b00, 2'b00, 1'b0);

    tp(2'b01, 2'b01);
    tp(2'b01, 2'b00);
    tp(2'b10, 2'b11);
    tp(2'b11, 2'b00);

    tp(2'b01, 2'b01);
    e_gs = 3'd2;
    e_ts = 2'b00;
    tick(2'b10, 2'b00, 1'b1);
    tick(2'b00, 2'b00, 1'b0);

    tp(2'b01, 2'b01);
    ignition = 1'b0;
    hazard = 1'b1;
    e_gs = 3'd0;
    e_gi = 0;
`ifdef VEHICLE_CTRL_HAZARD_EN
    e_ts = 2'b10;
`else
    e_ts = 2'b00;
`endif
    repeat (10) tick(2'b00, 2'b00, 1'b0);
    hazard = 1'b0;
    e_ts = 2'b00;
    repeat (2) tick(2'b00, 2'b00, 1'b0);
    ignition = 1'b1;
    e_gs = 3'd1;
    tick(2'b00, 2'b00, 1'b0);

    gp(2'b10, 3'd2, 0, 1'b0);
    gp(2'b10, 3'd3, 0, 1'b0);
    gp(2'b10, 3'd4, 1, 1'b0);
    gp(2'b10, 3'd4, 2, 1'b0);
    gp(2'b10, 3'd4, 3, 1'b0);
    e_ts = 2'b11;
    tick(2'b00, 2'b10, 1'b0);
    repeat (5) tick(2'b00, 2'b00, 1'b0);
    ignition = 1'b0;
    e_gs = 3'd0;
    e_gi = 0;
    e_ts = 2'b00;
    tick(2'b10, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
    ignition = 1'b1;
    e_gs = 3'd1;
    tick(2'b00, 2'b00, 1'b0);

    e_ts = 2'b01;
    tick(2'b00, 2'b01, 1'b0);
    repeat (2) tick(2'b00, 2'b00, 1'b0);
    reset = 1'b1;
    e_gs = 3'd0;
    e_ts = 2'b00;
    tick(2'b10, 2'b00, 1'b0);
    reset = 1'b0;
    e_gs = 3'd1;
    tick(2'b00, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
